// File: rtl/ibex_xif_pf_pkg.sv
// Shared types and helpers for the parametrised instruction prefetch buffer.
package ibex_xif_pf_pkg;

    // Width of the dropped-response counter.
    localparam int PfDiscardCntW = 16;

    // One buffered fetch result.
    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } pf_entry_t;

    // Bus request FSM: nothing pending, or a request waiting for its grant.
    typedef enum logic {
        PF_IDLE = 1'b0,
        PF_REQ  = 1'b1
    } pf_state_e;

    // Bits needed to hold a counter that runs from 0 to n inclusive.
    function automatic int pf_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ibex_xif_fetch_fifo_n.sv
// Circular buffer of fetched words. Same-cycle clear, push/pop when full,
// pop on empty is ignored. Head entry is readable combinationally so a word
// pushed in one cycle is visible at the output in the next.
module ibex_xif_fetch_fifo_n
    import ibex_xif_pf_pkg::*;
#(
    parameter int Depth    = 3,
    parameter bit ResetAll = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  pf_entry_t                 entry_i,
    input  logic                      pop_i,
    output logic                      valid_o,
    output pf_entry_t                 head_o,
    output logic [pf_cnt_w(Depth)-1:0] count_o
);

    localparam int CntW = pf_cnt_w(Depth);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_cnt;
    pf_entry_t       w_mem [Depth];

    logic w_pop;
    logic w_push;
    logic w_wr_en;

    assign w_pop   = pop_i & (r_cnt != '0);
    // A push into a full buffer only fits when the head leaves the same cycle.
    assign w_push  = push_i & ((r_cnt != FullCnt) | w_pop);
    assign w_wr_en = w_push & ~clear_i;

    // Pointer and occupancy tracking; clear wins over push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (clear_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
        end
    end

    // Storage: one register per slot, optionally reset.
    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_slot
            pf_entry_t r_entry;
            if (ResetAll) begin : g_rst
                // Slot write with reset of data/address bits.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_entry <= '0;
                    end else if (w_wr_en && (r_wr_ptr == PtrW'(gi))) begin
                        r_entry <= entry_i;
                    end
                end
            end else begin : g_norst
                // Slot write without reset; contents are don't-care until pushed.
                always_ff @(posedge clk_i) begin
                    if (w_wr_en && (r_wr_ptr == PtrW'(gi))) begin
                        r_entry <= entry_i;
                    end
                end
            end
            assign w_mem[gi] = r_entry;
        end
    endgenerate

    assign valid_o = (r_cnt != '0);
    assign head_o  = w_mem[r_rd_ptr];
    assign count_o = r_cnt;

endmodule

// File: rtl/ibex_xif_prefetch_buffer_n.sv
// Parametrised instruction prefetcher: keeps up to NumOutstanding requests in
// flight on a req/gnt + in-order rvalid bus and buffers up to FifoDepth words.
// Optional feature macro: IBEX_XIF_PF_DISCARD_CNT_EN enables a saturating
// count of responses dropped because of branches (otherwise discard_cnt_o = 0).
module ibex_xif_prefetch_buffer_n
    import ibex_xif_pf_pkg::*;
#(
    parameter int NumOutstanding = 2,
    parameter int FifoDepth      = 3,
    parameter bit ResetAll       = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     branch_i,
    input  logic [31:0]              addr_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [31:0]              rdata_o,
    output logic [31:0]              addr_o,
    output logic                     err_o,
    output logic                     instr_req_o,
    input  logic                     instr_gnt_i,
    output logic [31:0]              instr_addr_o,
    input  logic [31:0]              instr_rdata_i,
    input  logic                     instr_err_i,
    input  logic                     instr_rvalid_i,
    output logic                     busy_o,
    output logic [PfDiscardCntW-1:0] discard_cnt_o
);

    localparam int OutW     = pf_cnt_w(NumOutstanding);
    localparam int FifoCntW = pf_cnt_w(FifoDepth);
    localparam logic [31:0] FifoDepthU = FifoDepth;
    localparam logic [31:0] NumOutU    = NumOutstanding;

    generate
        if ((FifoDepth < NumOutstanding) || (NumOutstanding < 1) || (NumOutstanding > 8)) begin : g_cfg_check
            $error("ibex_xif_prefetch_buffer_n: need 1 <= NumOutstanding <= 8 and FifoDepth >= NumOutstanding");
        end
    endgenerate

    // Control state
    pf_state_e       r_state;
    pf_state_e       w_state_next;
    logic [OutW-1:0] r_out_cnt;
    logic [OutW-1:0] w_out_next;
    logic [OutW-1:0] r_disc_pend;
    logic [OutW-1:0] w_disc_base;
    logic [OutW-1:0] w_disc_next;
    logic            r_branch_pend;
    logic            w_branch_pend_next;

    // Address state
    logic [31:0] r_fetch_addr;
    logic [31:0] r_req_addr;
    logic [31:0] r_resp_addr;
    logic [31:0] w_fetch_addr_next;
    logic [31:0] w_fetch_base;
    logic [31:0] w_req_addr_next;
    logic [31:0] w_resp_addr_next;
    logic [31:0] w_branch_addr;

    // Request / response decode
    logic          w_instr_req;
    logic [31:0]   w_instr_addr;
    logic          w_issue_new;
    logic          w_gnt;
    logic          w_gnt_disc;
    logic          w_drop;
    logic          w_push;
    logic          w_credit;
    logic [31:0]   w_occupancy;
    logic          w_unused_addr0;

    // FIFO interface
    logic [FifoCntW-1:0] w_fifo_cnt;
    logic                w_fifo_valid;
    pf_entry_t           w_fifo_head;
    pf_entry_t           w_push_entry;

    assign w_unused_addr0 = addr_i[0];
    assign w_branch_addr  = {addr_i[31:2], 2'b00};

    // A branch empties the buffer this cycle, so its occupancy does not limit
    // the first fetch towards the new target.
    assign w_occupancy = (branch_i ? 32'd0 : 32'(w_fifo_cnt)) + 32'(r_out_cnt);
    assign w_credit    = req_i & (w_occupancy < FifoDepthU) & (32'(r_out_cnt) < NumOutU);

    // Request FSM: issue from IDLE when credit allows, hold address in REQ until granted.
    always_comb begin
        w_state_next = r_state;
        w_instr_req  = 1'b0;
        w_instr_addr = r_req_addr;
        w_issue_new  = 1'b0;
        case (r_state)
            PF_IDLE: begin
                if (w_credit && !rst_i) begin
                    w_instr_req  = 1'b1;
                    w_issue_new  = 1'b1;
                    w_instr_addr = branch_i ? w_branch_addr : r_fetch_addr;
                    if (!instr_gnt_i) begin
                        w_state_next = PF_REQ;
                    end
                end
            end
            PF_REQ: begin
                w_instr_req = ~rst_i;
                if (instr_gnt_i) begin
                    w_state_next = PF_IDLE;
                end
            end
            default: begin
                w_state_next = PF_IDLE;
            end
        endcase
    end

    assign w_gnt = w_instr_req & instr_gnt_i;
    // A stored request that saw a branch (earlier or now) fetches the stale path.
    assign w_gnt_disc = w_gnt & (r_state == PF_REQ) & (r_branch_pend | branch_i);

    // Responses are dropped while stale ones are still owed, or on a branch cycle.
    assign w_drop = instr_rvalid_i & (branch_i | (r_disc_pend != '0));
    assign w_push = instr_rvalid_i & ~w_drop;

    // Counter and address next-state computation.
    always_comb begin
        w_out_next         = r_out_cnt + OutW'(w_gnt) - OutW'(instr_rvalid_i);
        w_disc_base        = branch_i ? r_out_cnt : r_disc_pend;
        w_disc_next        = w_disc_base - OutW'(w_drop) + OutW'(w_gnt_disc);
        w_branch_pend_next = r_branch_pend;
        if (w_gnt) begin
            w_branch_pend_next = 1'b0;
        end else if ((r_state == PF_REQ) && branch_i) begin
            w_branch_pend_next = 1'b1;
        end
        w_fetch_base      = branch_i ? w_branch_addr : r_fetch_addr;
        w_fetch_addr_next = w_issue_new ? (w_fetch_base + 32'd4) : w_fetch_base;
        w_req_addr_next   = w_issue_new ? w_instr_addr : r_req_addr;
        // First word after a branch keeps the halfword offset of the target.
        w_resp_addr_next  = r_resp_addr;
        if (branch_i) begin
            w_resp_addr_next = {addr_i[31:1], 1'b0};
        end else if (w_push) begin
            w_resp_addr_next = {r_resp_addr[31:2], 2'b00} + 32'd4;
        end
    end

    // Control flops: FSM state, outstanding and discard bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= PF_IDLE;
            r_out_cnt     <= '0;
            r_disc_pend   <= '0;
            r_branch_pend <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_out_cnt     <= w_out_next;
            r_disc_pend   <= w_disc_next;
            r_branch_pend <= w_branch_pend_next;
        end
    end

    generate
        if (ResetAll) begin : g_addr_rst
            // Address flops with reset.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_fetch_addr <= '0;
                    r_req_addr   <= '0;
                    r_resp_addr  <= '0;
                end else begin
                    r_fetch_addr <= w_fetch_addr_next;
                    r_req_addr   <= w_req_addr_next;
                    r_resp_addr  <= w_resp_addr_next;
                end
            end
        end else begin : g_addr_norst
            // Address flops without reset; a branch always precedes their use.
            always_ff @(posedge clk_i) begin
                r_fetch_addr <= w_fetch_addr_next;
                r_req_addr   <= w_req_addr_next;
                r_resp_addr  <= w_resp_addr_next;
            end
        end
    endgenerate

    assign w_push_entry.rdata = instr_rdata_i;
    assign w_push_entry.addr  = r_resp_addr;
    assign w_push_entry.err   = instr_err_i;

    ibex_xif_fetch_fifo_n #(
        .Depth    (FifoDepth),
        .ResetAll (ResetAll)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (branch_i),
        .push_i  (w_push),
        .entry_i (w_push_entry),
        .pop_i   (ready_i),
        .valid_o (w_fifo_valid),
        .head_o  (w_fifo_head),
        .count_o (w_fifo_cnt)
    );

`ifdef IBEX_XIF_PF_DISCARD_CNT_EN
    logic [PfDiscardCntW-1:0] r_discard_cnt;

    // Saturating count of dropped responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_discard_cnt <= '0;
        end else if (w_drop && (r_discard_cnt != '1)) begin
            r_discard_cnt <= r_discard_cnt + 1'b1;
        end
    end

    assign discard_cnt_o = r_discard_cnt;
`else
    assign discard_cnt_o = '0;
`endif

    // Outputs are forced to zero when not valid so unreset storage never leaks.
    assign valid_o      = w_fifo_valid;
    assign rdata_o      = w_fifo_valid ? w_fifo_head.rdata : '0;
    assign addr_o       = w_fifo_valid ? w_fifo_head.addr : '0;
    assign err_o        = w_fifo_valid & w_fifo_head.err;
    assign instr_req_o  = w_instr_req;
    assign instr_addr_o = w_instr_req ? w_instr_addr : '0;
    assign busy_o       = w_instr_req | (r_out_cnt != '0);

endmodule
